// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase scheduler.
// Lamp encodings, approach numbering, controller phases and a timer-sizing helper.
// Pure declarations: no latency and no flow control.
package traffic_pkg;

  typedef enum logic [2:0] {
    L_RED    = 3'b100,
    L_YELLOW = 3'b010,
    L_GREEN  = 3'b001
  } light_t;

  typedef enum bit [1:0] {N, E, S, W} dir_t;

  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} phase_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Timing-tick source: one-cycle pulse every TICK_DIV clocks.
// Pulse is registered; with TICK_DIV=1 it is high every cycle after reset.
// No backpressure: free-running divider.
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk_in,
  input  logic rstn,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rstn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated 4-way phase scheduler with min/max green, yellow, all-red and emergency override.
// All outputs registered with the state; a decision taken on a tick is visible the next cycle.
// No backpressure: requests are level inputs latched into pending until their green begins.
module traffic_phase_scheduler #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk_in,
  input  logic       rstn,
  input  logic [3:0] req,
  input  logic       emerg_valid,
  input  logic [1:0] emerg_dir,
  output logic [2:0] north,
  output logic [2:0] east,
  output logic [2:0] south,
  output logic [2:0] west,
  output logic [1:0] active_dir,
  output logic [3:0] pending,
  output logic       phase_start
);
  import traffic_pkg::*;

  localparam int TW = $clog2(max3(MAX_GREEN, YELLOW_T, ALLRED_T) + 1);
  localparam logic [TW-1:0] T_MIN  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAX1 = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(MAX_GREEN);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);

  // First pending approach strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic dir_t rr_pick(input dir_t last, input logic [3:0] p);
    dir_t sel;
    sel = last;
    for (int k = 4; k >= 1; k--) begin
      if (p[2'(int'(last) + k)]) sel = dir_t'(2'(int'(last) + k));
    end
    return sel;
  endfunction

  logic             tick;
  phase_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  dir_t             dir_q, dir_d;
  logic [3:0]       pend_q, pend_d;
  logic             ps_q, ps_d;
  logic [3:0][2:0]  lamp_q, lamp_d;
  logic             grant;
  logic             green_exit;
  logic [3:0]       others;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_in (clk_in),
    .rstn   (rstn),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dir_d      = dir_q;
    pend_d     = pend_q | req;
    ps_d       = 1'b0;
    grant      = 1'b0;
    others     = pend_q & ~(4'b0001 << dir_q);
    green_exit = (emerg_valid && (dir_t'(emerg_dir) != dir_q)) ||
                 (!emerg_valid && (timer_q >= T_MIN) && (|others) &&
                  (!req[dir_q] || (timer_q >= T_MAX1)));

    case (state_q)
      ALLRED: if (tick) begin
        if (timer_q >= T_AR) begin
          if (emerg_valid) begin
            grant = 1'b1;
            dir_d = dir_t'(emerg_dir);
          end else if (|pend_q) begin
            grant = 1'b1;
            dir_d = rr_pick(dir_q, pend_q);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GREEN: if (tick) begin
        if (green_exit) begin
          state_d = YELLOW;
          timer_d = '0;
        end else if (timer_q < T_SAT) begin
          timer_d = timer_q + TW'(1);
        end
      end
      YELLOW: if (tick) begin
        if (timer_q >= T_YEL) begin
          state_d = ALLRED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ALLRED;
    endcase

    // The clear on grant overrides a same-cycle request for the granted approach.
    if (grant) begin
      state_d       = GREEN;
      timer_d       = '0;
      ps_d          = 1'b1;
      pend_d[dir_d] = 1'b0;
    end

    lamp_d = {4{3'(L_RED)}};
    if (state_d == GREEN)  lamp_d[dir_d] = L_GREEN;
    if (state_d == YELLOW) lamp_d[dir_d] = L_YELLOW;
  end

  always_ff @(posedge clk_in) begin
    if (rstn) begin
      state_q <= ALLRED;
      timer_q <= '0;
      dir_q   <= N;
      pend_q  <= '0;
      ps_q    <= 1'b0;
      lamp_q  <= {4{3'(L_RED)}};
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      ps_q    <= ps_d;
      lamp_q  <= lamp_d;
    end
  end

  assign north       = lamp_q[0];
  assign east        = lamp_q[1];
  assign south       = lamp_q[2];
  assign west        = lamp_q[3];
  assign active_dir  = 2'(dir_q);
  assign pending     = pend_q;
  assign phase_start = ps_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus queues the expected lamp events, a monitor checks every lamp change.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] RD = 3'b100;
  localparam logic [2:0] YL = 3'b010;
  localparam logic [2:0] GR = 3'b001;

  logic       clk_in = 1'b0;
  logic       rstn;
  logic [3:0] req;
  logic       emerg_valid;
  logic [1:0] emerg_dir;
  logic [2:0] north, east, south, west;
  logic [1:0] active_dir;
  logic [3:0] pending;
  logic       phase_start;

  traffic_phase_scheduler #(
    .TICK_DIV(1), .MIN_GREEN(2), .MAX_GREEN(4), .YELLOW_T(1), .ALLRED_T(1)
  ) dut (
    .clk_in(clk_in), .rstn(rstn), .req(req), .emerg_valid(emerg_valid),
    .emerg_dir(emerg_dir), .north(north), .east(east), .south(south), .west(west),
    .active_dir(active_dir), .pending(pending), .phase_start(phase_start)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [11:0] lamps;
    logic [1:0]  dir;
    logic        ps;
    logic [3:0]  pend;
    int          gap;   // cycles since previous lamp change; 0 = not checked
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 0;
  bit   done = 0;

  function automatic logic [11:0] lamps_of(input int d, input logic [2:0] c);
    logic [11:0] v;
    v = {4{RD}};
    if (d >= 0) v[11 - 3*d -: 3] = c;
    return v;
  endfunction

  task automatic exp_ev(input int d, input logic [2:0] c, input int ad, input logic ps,
                        input logic [3:0] pd, input int gap);
    exp_t e;
    e.lamps = lamps_of(d, c);
    e.dir   = 2'(ad);
    e.ps    = ps;
    e.pend  = pd;
    e.gap   = gap;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    repeat (2) step();
    rstn = 1'b0;
    repeat (3) step();
  endtask

  // Monitor: pops one expected event per observed lamp change.
  initial begin : monitor
    logic [11:0] prev, cur;
    int cyc, last;
    exp_t e;
    int nonred;
    wait (mon_en);
    prev = {north, east, south, west};
    cyc  = 0;
    last = 0;
    while (!done) begin
      @(negedge clk_in);
      cyc++;
      cur = {north, east, south, west};
      nonred = 0;
      for (int i = 0; i < 4; i++) if (cur[3*i +: 3] != RD) nonred++;
      chk("one_nonred_lamp", (nonred <= 1), 1);
      if (cur != prev) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_change: got lamps %03h at cycle %0d, expected no change", cur, cyc);
        end else begin
          e = q.pop_front();
          chk("ev_lamps", cur, e.lamps);
          chk("ev_active_dir", active_dir, e.dir);
          chk("ev_phase_start", phase_start, e.ps);
          chk("ev_pending", pending, e.pend);
          if (e.gap != 0) chk("ev_dwell", cyc - last, e.gap);
        end
        last = cyc;
        prev = cur;
      end else begin
        chk("no_spurious_phase_start", phase_start, 0);
      end
    end
  end

  initial begin : stimulus
    logic [11:0] all_red;
    all_red     = lamps_of(-1, RD);
    rstn        = 1'b1;
    req         = 4'b0;
    emerg_valid = 1'b0;
    emerg_dir   = 2'd0;
    repeat (3) step();
    chk("rst_lamps", {north, east, south, west}, all_red);
    chk("rst_active_dir", active_dir, 0);
    chk("rst_pending", pending, 0);
    chk("rst_phase_start", phase_start, 0);
    mon_en = 1'b1;
    rstn   = 1'b0;
    repeat (3) step();

    // Idle: no demand keeps everything red.
    repeat (20) step();
    chk("idle_lamps", {north, east, south, west}, all_red);
    chk("idle_pending", pending, 0);

    // Single north pulse: north green then rests.
    exp_ev(0, GR, 0, 1, 4'b0000, 0);
    req = 4'b0001; step(); req = 4'b0000;
    repeat (12) step();
    chk("rest_north_green", north, GR);

    // North held with E and W waiting: max green, yellow, all-red, east.
    exp_ev(-1, RD, 0, 0, 4'b0000, 0);
    do_reset();
    exp_ev(0,  GR, 0, 1, 4'b1010, 0);
    exp_ev(0,  YL, 0, 0, 4'b1011, 4);
    exp_ev(-1, RD, 0, 0, 4'b1011, 1);
    exp_ev(1,  GR, 1, 1, 4'b1001, 1);
    exp_ev(-1, RD, 0, 0, 4'b0000, 0);
    req = 4'b0001; step();
    req = 4'b1011; repeat (7) step();
    req = 4'b0000;
    do_reset();

    // North released early with south waiting: yellow at min green, then south.
    exp_ev(0,  GR, 0, 1, 4'b0100, 0);
    exp_ev(0,  YL, 0, 0, 4'b0100, 2);
    exp_ev(-1, RD, 0, 0, 4'b0100, 1);
    exp_ev(2,  GR, 2, 1, 4'b0000, 1);
    req = 4'b0001; step();
    req = 4'b0101; step();
    req = 4'b0100; repeat (4) step();
    req = 4'b0000; repeat (6) step();

    // Emergency for west during east green; north request survives the override.
    exp_ev(-1, RD, 0, 0, 4'b0000, 0);
    do_reset();
    exp_ev(1,  GR, 1, 1, 4'b0000, 0);
    exp_ev(1,  YL, 1, 0, 4'b0001, 1);
    exp_ev(-1, RD, 1, 0, 4'b0001, 1);
    exp_ev(3,  GR, 3, 1, 4'b0001, 1);
    exp_ev(3,  YL, 3, 0, 4'b0001, 10);
    exp_ev(-1, RD, 3, 0, 4'b0001, 1);
    exp_ev(0,  GR, 0, 1, 4'b0000, 1);
    req = 4'b0010; step();
    req = 4'b0000; step();
    req = 4'b0001; emerg_valid = 1'b1; emerg_dir = 2'd3; step();
    req = 4'b0000; repeat (11) step();
    emerg_valid = 1'b0; repeat (8) step();

    // Reset pulse during yellow returns to reset values.
    exp_ev(-1, RD, 0, 0, 4'b0000, 0);
    do_reset();
    exp_ev(1,  GR, 1, 1, 4'b0000, 0);
    exp_ev(1,  YL, 1, 0, 4'b0100, 2);
    exp_ev(-1, RD, 0, 0, 4'b0000, 1);
    req = 4'b0010; step();
    req = 4'b0000; step();
    req = 4'b0100; step();
    req = 4'b0000; step();
    rstn = 1'b1; step();
    rstn = 1'b0;
    chk("midrst_lamps", {north, east, south, west}, all_red);
    chk("midrst_pending", pending, 0);
    chk("midrst_active_dir", active_dir, 0);
    repeat (10) step();

    chk("scoreboard_drained", q.size(), 0);
    done = 1'b1;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
